ram_access_master: RTL and testbench
====================================

Name: ram_access_master

Overview:
Initiator-side controller for the byte-addressed single-port RAM responder used by the openmips wrapper. It accepts one load/store request at a time from the CPU MEM stage. It drives the responder's cs/we/addr/wdata pins and returns sign- or zero-extended load data. It performs byte-lane mapping so a store followed by a load of the same size and address returns the stored value (responder reads big-endian, writes lane i to addr+i).

Parameters:
DATA_WIDTH, 32, RAM data bus width (4 byte lanes)
ADDR_WIDTH, 30, byte address width
RAM_DEPTH, 53248, number of valid byte locations (0..RAM_DEPTH-1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid&&req_ready at posedge
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (error)
req_signed  input  1  sign-extend load result
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store value, right-justified
rsp_valid  output  1  one-cycle completion pulse
rsp_err  output  1  qualifies rsp_valid: misaligned/out-of-range/reserved size
rsp_rdata  output  32  load result, valid with rsp_valid on loads
ram_cs  output  1  to responder cs
ram_we  output  4  to responder we byte mask
ram_addr  output  ADDR_WIDTH  to responder addr
ram_wdata  output  32  to responder wdata
ram_rdata  input  32  from responder rdata (1-cycle registered read)

Behaviour:
- Reset (async, rst_n=0): state IDLE; ram_cs=0, ram_we=0, ram_addr=0, ram_wdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0. Abort any access in flight with no response.
- All outputs are registered. req_ready=1 only in IDLE.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE, accepted and legal -> ISSUE; accepted and illegal -> DONE with err; otherwise stay in IDLE.
  - ISSUE: ram_cs=1 for exactly one cycle. Store -> DONE; load -> WAIT.
  - WAIT: ram_cs=0; capture the extracted ram_rdata at the cycle end -> DONE.
  - DONE: rsp_valid=1 for one cycle -> IDLE.
- Timing, with acceptance at the edge ending cycle T:
  - store: cs in T+1, rsp_valid in T+2.
  - load: cs in T+1, responder data in T+2, rsp_valid and rsp_rdata in T+3.
  - error: rsp_valid=rsp_err=1 in T+1; ram_cs never asserted.
- Maximum throughput is one store per 3 cycles or one load per 4 cycles. No request is accepted while busy.
- Legality checks:
  - halfword needs addr[0]=0; word needs addr[1:0]=0.
  - addr+bytes-1 must be <= RAM_DEPTH-1.
  - size 11 is illegal.
- ram_addr = req_addr unmodified, since the responder is byte-indexed.
- Store lane mapping (lane i lands at addr+i):
  - byte: we=0001, wdata[7:0]=v[7:0].
  - half: we=0011, wdata[15:0]={v[7:0],v[15:8]}.
  - word: we=1111, wdata={v[7:0],v[15:8],v[23:16],v[31:24]}.
  - Unused lanes are 0.
- Load: ram_we=0000, ram_wdata=0.
  - byte result from rdata[31:24]; half from rdata[31:16]; word is rdata.
  - Sign-extend if req_signed, else zero-extend; req_signed is ignored for word.
- Request fields are latched at acceptance; input changes afterwards have no effect.
- rsp_err=0 on legal completions. rsp_rdata holds its last value outside rsp_valid and is 0 after a store or error.
- ram_cs, ram_we, ram_wdata return to 0 in all states except ISSUE.

Test Plan:
- Store word 0x12345678 @0x100 -> T+1 cs=1, we=1111, addr=0x100, wdata=0x78563412; rsp_valid T+2, err=0. Then load word @0x100 -> rsp_rdata=0x12345678 at T+3.
- Store byte 0x80 @0x103, then signed byte load @0x103 -> 0xFFFFFF80; unsigned load -> 0x00000080.
- Store half 0xBEEF @0x200 (we=0011, wdata=0x0000EFBE), then signed half load -> 0xFFFFBEEF; unsigned byte load @0x201 -> 0x000000EF.
- Half load @0x101, word load @0x102, size=11, word @53246 -> each rsp_valid=rsp_err=1 at T+1, ram_cs stays 0.
- Hold req_valid=1 continuously with 3 loads -> req_ready low during ISSUE/WAIT/DONE; accepts spaced 4 cycles; responses in order.
- Assert rst_n=0 during WAIT -> all outputs 0 immediately, no rsp_valid; after release a new store completes normally.

Source files
------------

// File: rtl/ram_access_master_if.sv
// ram_access_master_if: bundles the CPU-side request/response handshake and the RAM responder
// pins of ram_access_master.
//   req_*     : load/store request from the MEM stage (valid/ready handshake)
//   rsp_*     : one-cycle completion pulse with error flag and load data
//   ram_*     : responder pins (cs, byte write mask, byte address, write/read data)
// Modports: master = the access controller, slave = CPU stage plus RAM responder.
interface ram_access_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 30
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [1:0]              req_size;
  logic                    req_signed;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;

  logic                    rsp_valid;
  logic                    rsp_err;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  logic                    ram_cs;
  logic [DATA_WIDTH/8-1:0] ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, ram_cs, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, ram_cs, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_access_master.sv
// ram_access_master: initiator-side controller for a byte-addressed single-port RAM responder.
// Accepts one load/store at a time, checks legality (alignment, range, size), maps store bytes
// onto responder lanes (lane i lands at addr+i) and returns sign/zero-extended load data
// (responder returns big-endian: rdata[31:24] is the byte at addr).
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset, aborts any access in flight without a response
//   bus   : ram_access_master_if.master (request, response and responder pins)
// Timing (accept at edge ending cycle T): store cs T+1, rsp T+2; load cs T+1, rsp T+3;
// illegal request rsp+err in T+1 with cs never asserted.
module ram_access_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned RAM_DEPTH  = 53248
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_access_master_if.master bus
);

  localparam logic [ADDR_WIDTH:0] LastByte = (ADDR_WIDTH+1)'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    signed_q, signed_d;
  logic                    ram_cs_q, ram_cs_d;
  logic [3:0]              ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                    size_ok;
  logic                    align_ok;
  logic [ADDR_WIDTH:0]     last_addr;
  logic                    legal;
  logic [3:0]              st_we;
  logic [DATA_WIDTH-1:0]   st_wdata;
  logic [DATA_WIDTH-1:0]   ld_data;

  // Legality of the incoming request: last byte touched must stay inside the RAM.
  always_comb begin
    size_ok   = 1'b1;
    align_ok  = 1'b1;
    last_addr = {1'b0, bus.req_addr};
    unique case (bus.req_size)
      2'b00: ;
      2'b01: begin
        align_ok  = ~bus.req_addr[0];
        last_addr = {1'b0, bus.req_addr} + (ADDR_WIDTH+1)'(1);
      end
      2'b10: begin
        align_ok  = (bus.req_addr[1:0] == 2'b00);
        last_addr = {1'b0, bus.req_addr} + (ADDR_WIDTH+1)'(3);
      end
      default: size_ok = 1'b0;
    endcase
    legal = size_ok && align_ok && (last_addr <= LastByte);
  end

  // Store lane mapping: byte at addr+i goes on lane i, so the value is byte-reversed.
  always_comb begin
    unique case (bus.req_size)
      2'b00: begin
        st_we    = 4'b0001;
        st_wdata = {24'h0, bus.req_wdata[7:0]};
      end
      2'b01: begin
        st_we    = 4'b0011;
        st_wdata = {16'h0, bus.req_wdata[7:0], bus.req_wdata[15:8]};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = {bus.req_wdata[7:0], bus.req_wdata[15:8],
                    bus.req_wdata[23:16], bus.req_wdata[31:24]};
      end
    endcase
  end

  // Load extraction from the big-endian responder word, using the latched request fields.
  always_comb begin
    unique case (size_q)
      2'b00:   ld_data = {{24{signed_q & bus.ram_rdata[31]}}, bus.ram_rdata[31:24]};
      2'b01:   ld_data = {{16{signed_q & bus.ram_rdata[31]}}, bus.ram_rdata[31:16]};
      default: ld_data = bus.ram_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    ram_cs_d    = 1'b0;
    ram_we_d    = 4'b0000;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          if (legal) begin
            state_d    = StIssue;
            ram_cs_d   = 1'b1;
            ram_addr_d = bus.req_addr;
            if (bus.req_we) begin
              ram_we_d    = st_we;
              ram_wdata_d = st_wdata;
            end
          end else begin
            state_d     = StDone;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d     = StDone;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        state_d     = StDone;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ld_data;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 4'b0000;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.ram_cs    = ram_cs_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_access_master.sv
// Directed bench for ram_access_master with a byte-addressed responder model
// (lane i writes addr+i, registered big-endian read).
module tb_ram_access_master;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  logic [7:0]  mem [0:65535];
  logic [1:0]  b2b_size [3];
  logic        b2b_sgn  [3];
  logic [29:0] b2b_addr [3];
  logic [31:0] b2b_exp  [3];

  ram_access_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(30)) bus ();

  ram_access_master #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(30),
    .RAM_DEPTH (53248)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Responder: one-cycle registered read, byte-lane writes.
  always @(posedge clk) begin
    if (bus.ram_cs) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.ram_we[i]) mem[bus.ram_addr[15:0] + 16'(i)] <= bus.ram_wdata[8*i +: 8];
      end
      bus.ram_rdata <= {mem[bus.ram_addr[15:0]], mem[bus.ram_addr[15:0] + 16'd1],
                        mem[bus.ram_addr[15:0] + 16'd2], mem[bus.ram_addr[15:0] + 16'd3]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction with per-cycle checks; fields are scrambled after acceptance.
  task automatic txn(input string nm, input logic we, input logic [1:0] size, input logic sgn,
                     input logic [29:0] addr, input logic [31:0] wdata, input logic exp_err,
                     input logic [3:0] exp_we, input logic [31:0] exp_wd,
                     input logic [31:0] exp_rd);
    @(negedge clk);
    check({nm, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_size   = ~size;
    bus.req_signed = ~sgn;
    bus.req_addr   = ~addr;
    bus.req_wdata  = ~wdata;
    if (exp_err) begin
      check({nm, " err valid"}, 32'(bus.rsp_valid), 32'd1);
      check({nm, " err flag"}, 32'(bus.rsp_err), 32'd1);
      check({nm, " err cs"}, 32'(bus.ram_cs), 32'd0);
      check({nm, " err rdata"}, bus.rsp_rdata, 32'd0);
    end else begin
      check({nm, " cs"}, 32'(bus.ram_cs), 32'd1);
      check({nm, " we"}, 32'(bus.ram_we), 32'(exp_we));
      check({nm, " addr"}, 32'(bus.ram_addr), 32'(addr));
      check({nm, " wdata"}, bus.ram_wdata, exp_wd);
      check({nm, " early valid"}, 32'(bus.rsp_valid), 32'd0);
      if (!we) begin
        @(negedge clk);
        check({nm, " wait valid"}, 32'(bus.rsp_valid), 32'd0);
        check({nm, " wait cs"}, 32'(bus.ram_cs), 32'd0);
      end
      @(negedge clk);
      check({nm, " valid"}, 32'(bus.rsp_valid), 32'd1);
      check({nm, " err"}, 32'(bus.rsp_err), 32'd0);
      check({nm, " rdata"}, bus.rsp_rdata, exp_rd);
      check({nm, " done cs"}, 32'(bus.ram_cs), 32'd0);
    end
    @(negedge clk);
    check({nm, " post valid"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    bus.ram_rdata  = 32'h0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    rst_n          = 1'b0;
    #1;
    check("rst cs", 32'(bus.ram_cs), 32'd0);
    check("rst we", 32'(bus.ram_we), 32'd0);
    check("rst addr", 32'(bus.ram_addr), 32'd0);
    check("rst wdata", bus.ram_wdata, 32'd0);
    check("rst valid", 32'(bus.rsp_valid), 32'd0);
    check("rst err", 32'(bus.rsp_err), 32'd0);
    check("rst rdata", bus.rsp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Word round trip
    txn("st_w100", 1'b1, 2'b10, 1'b0, 30'h100, 32'h12345678, 1'b0, 4'b1111, 32'h78563412, 32'h0);
    txn("ld_w100", 1'b0, 2'b10, 1'b0, 30'h100, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h12345678);
    // Byte store/load, signed and unsigned
    txn("st_b103", 1'b1, 2'b00, 1'b0, 30'h103, 32'hFFFFFF80, 1'b0, 4'b0001, 32'h80, 32'h0);
    txn("ld_sb103", 1'b0, 2'b00, 1'b1, 30'h103, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFFFF80);
    txn("ld_ub103", 1'b0, 2'b00, 1'b0, 30'h103, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h00000080);
    txn("ld_sw100", 1'b0, 2'b10, 1'b1, 30'h100, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h12345680);
    // Halfword
    txn("st_h200", 1'b1, 2'b01, 1'b0, 30'h200, 32'hDEADBEEF, 1'b0, 4'b0011, 32'h0000EFBE, 32'h0);
    txn("ld_sh200", 1'b0, 2'b01, 1'b1, 30'h200, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFFBEEF);
    txn("ld_uh200", 1'b0, 2'b01, 1'b0, 30'h200, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0000BEEF);
    txn("ld_ub201", 1'b0, 2'b00, 1'b0, 30'h201, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h000000EF);
    // Errors
    txn("e_h101", 1'b0, 2'b01, 1'b0, 30'h101, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0);
    txn("e_w102", 1'b0, 2'b10, 1'b0, 30'h102, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0);
    txn("e_sz11", 1'b1, 2'b11, 1'b0, 30'h100, 32'h55, 1'b1, 4'b0, 32'h0, 32'h0);
    txn("e_w53246", 1'b0, 2'b10, 1'b0, 30'd53246, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0);
    txn("e_b53248", 1'b1, 2'b00, 1'b0, 30'd53248, 32'h77, 1'b1, 4'b0, 32'h0, 32'h0);
    // Top-of-RAM legal accesses
    txn("st_w53244", 1'b1, 2'b10, 1'b0, 30'd53244, 32'hA1B2C3D4, 1'b0, 4'b1111, 32'hD4C3B2A1,
        32'h0);
    txn("ld_w53244", 1'b0, 2'b10, 1'b0, 30'd53244, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hA1B2C3D4);
    txn("ld_ub53247", 1'b0, 2'b00, 1'b0, 30'd53247, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h000000D4);
    txn("ld_sh53246", 1'b0, 2'b01, 1'b1, 30'd53246, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFFC3D4);

    // Back-to-back loads with req_valid held high: one acceptance every 4 cycles
    b2b_size[0] = 2'b10; b2b_sgn[0] = 1'b0; b2b_addr[0] = 30'h100; b2b_exp[0] = 32'h12345680;
    b2b_size[1] = 2'b00; b2b_sgn[1] = 1'b1; b2b_addr[1] = 30'h103; b2b_exp[1] = 32'hFFFFFF80;
    b2b_size[2] = 2'b01; b2b_sgn[2] = 1'b1; b2b_addr[2] = 30'h200; b2b_exp[2] = 32'hFFFFBEEF;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("b2b ready idle", 32'(bus.req_ready), 32'd1);
      bus.req_size   = b2b_size[k];
      bus.req_signed = b2b_sgn[k];
      bus.req_addr   = b2b_addr[k];
      @(negedge clk);
      bus.req_addr = 30'h3FFFFFFF;
      check("b2b ready issue", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      check("b2b ready wait", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      check("b2b ready done", 32'(bus.req_ready), 32'd0);
      check("b2b valid", 32'(bus.rsp_valid), 32'd1);
      check("b2b rdata", bus.rsp_rdata, b2b_exp[k]);
      if (k == 2) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b idle valid", 32'(bus.rsp_valid), 32'd0);

    // Reset during WAIT aborts the load silently
    check("rw ready", 32'(bus.req_ready), 32'd1);
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 30'h100;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rw issue cs", 32'(bus.ram_cs), 32'd1);
    @(negedge clk);
    check("rw wait cs", 32'(bus.ram_cs), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rw cs", 32'(bus.ram_cs), 32'd0);
    check("rw we", 32'(bus.ram_we), 32'd0);
    check("rw addr", 32'(bus.ram_addr), 32'd0);
    check("rw wdata", bus.ram_wdata, 32'd0);
    check("rw valid", 32'(bus.rsp_valid), 32'd0);
    check("rw err", 32'(bus.rsp_err), 32'd0);
    check("rw rdata", bus.rsp_rdata, 32'd0);
    @(negedge clk);
    check("rw held valid", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rw rel valid", 32'(bus.rsp_valid), 32'd0);
    check("rw rel ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    check("rw rel valid2", 32'(bus.rsp_valid), 32'd0);
    txn("st_w300", 1'b1, 2'b10, 1'b0, 30'h300, 32'hCAFEF00D, 1'b0, 4'b1111, 32'h0DF0FECA, 32'h0);
    txn("ld_w300", 1'b0, 2'b10, 1'b0, 30'h300, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
